// File: rtl/regfile_pkg.sv
// Shared constants for the tiny16 register file: fixed register indices and
// default geometry / stack bounds.
package regfile_pkg;

  localparam int unsigned ZERO_IDX = 0;
  localparam int unsigned PC_IDX   = 1;
  localparam int unsigned SP_IDX   = 2;
  localparam int unsigned BA_IDX   = 3;
  localparam int unsigned RA_IDX   = 4;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_NREGS    = 16;
  localparam int unsigned DEF_SP_TOP   = 'h00FF;
  localparam int unsigned DEF_SP_LIMIT = 'h0080;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between decode/control (master) and the register file (slave).
interface register_file_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
);
  logic [AW-1:0]    rd_a_sel;
  logic [WIDTH-1:0] rd_a;
  logic [AW-1:0]    rd_b_sel;
  logic [WIDTH-1:0] rd_b;
  logic [AW-1:0]    wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             wr_hi_en;
  logic             wr_lo_en;
  logic             pc_inc;
  logic             pc_load;
  logic [WIDTH-1:0] pc_target;
  logic             sp_inc;
  logic             sp_dec;
  logic             stk_clr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] sp;
  logic             stk_ovf;
  logic             stk_unf;

  modport master (
    output rd_a_sel, rd_b_sel, wr_sel, wr_data, wr_en, wr_hi_en, wr_lo_en,
           pc_inc, pc_load, pc_target, sp_inc, sp_dec, stk_clr,
    input  rd_a, rd_b, pc, sp, stk_ovf, stk_unf
  );

  modport slave (
    input  rd_a_sel, rd_b_sel, wr_sel, wr_data, wr_en, wr_hi_en, wr_lo_en,
           pc_inc, pc_load, pc_target, sp_inc, sp_dec, stk_clr,
    output rd_a, rd_b, pc, sp, stk_ovf, stk_unf
  );
endinterface

// File: rtl/stack_ptr_ctrl.sv
// Stack pointer register with bounds checking, push/pop arbitration and
// sticky overflow/underflow flags. Stack grows downward from SP_TOP.
module stack_ptr_ctrl #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SP_TOP   = 16'h00FF,
  parameter logic [WIDTH-1:0] SP_LIMIT = 16'h0080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sp_inc,
  input  logic             sp_dec,
  input  logic             stk_clr,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_val,
  output logic [WIDTH-1:0] sp_q,
  output logic [WIDTH-1:0] sp_nxt,
  output logic             stk_ovf,
  output logic             stk_unf
);

  logic at_top, at_limit, ovf_ev, unf_ev;

  assign at_top   = (sp_q == SP_TOP);
  assign at_limit = (sp_q == SP_LIMIT);
  assign ovf_ev   = sp_dec && !sp_inc && at_limit;
  assign unf_ev   = sp_inc && !sp_dec && at_top;

  // Any push/pop request, even a cancelling pair, blocks a general write.
  always_comb begin
    sp_nxt = sp_q;
    if (sp_inc && sp_dec) begin
      sp_nxt = sp_q;
    end else if (sp_dec) begin
      if (!at_limit) sp_nxt = sp_q - WIDTH'(1);
    end else if (sp_inc) begin
      if (!at_top) sp_nxt = sp_q + WIDTH'(1);
    end else if (wr_hit) begin
      sp_nxt = wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q    <= SP_TOP;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      sp_q    <= sp_nxt;
      stk_ovf <= ovf_ev || (stk_ovf && !stk_clr);
      stk_unf <= unf_ev || (stk_unf && !stk_clr);
    end
  end

endmodule

// File: rtl/register_file.sv
// tiny16 register file: two read ports, byte-lane write port, PC and SP
// sequencing. Define REGFILE_BYPASS_EN to forward next-state values to reads.
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter logic [WIDTH-1:0] SP_TOP   = WIDTH'(DEF_SP_TOP),
  parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'(DEF_SP_LIMIT),
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);

  logic [WIDTH-1:0] gp_q [NREGS];
  logic [WIDTH-1:0] cur  [NREGS];
  logic [WIDTH-1:0] nxt  [NREGS];
  logic [WIDTH-1:0] pc_q, pc_nxt, sp_q, sp_nxt, sp_wr_val;
  logic             wr_any, sp_wr_hit;

  // Full word first, then each enabled byte lane takes wr_data[7:0].
  function automatic logic [WIDTH-1:0] merge_word(
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] data,
    input logic             en,
    input logic             hi_en,
    input logic             lo_en
  );
    logic [WIDTH-1:0] v;
    v = en ? data : old_val;
    if (hi_en) v[WIDTH-1 -: 8] = data[7:0];
    if (lo_en) v[7:0] = data[7:0];
    return v;
  endfunction

  assign wr_any    = bus.wr_en || bus.wr_hi_en || bus.wr_lo_en;
  assign sp_wr_hit = wr_any && (bus.wr_sel == AW'(SP_IDX));
  assign sp_wr_val = merge_word(sp_q, bus.wr_data, bus.wr_en, bus.wr_hi_en, bus.wr_lo_en);

  always_comb begin
    pc_nxt = pc_q;
    if (bus.pc_load) begin
      pc_nxt = bus.pc_target;
    end else if (bus.pc_inc) begin
      pc_nxt = pc_q + WIDTH'(1);
    end else if (wr_any && bus.wr_sel == AW'(PC_IDX)) begin
      pc_nxt = merge_word(pc_q, bus.wr_data, bus.wr_en, bus.wr_hi_en, bus.wr_lo_en);
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cur[i] = gp_q[i];
      nxt[i] = gp_q[i];
      if (wr_any && bus.wr_sel == AW'(i))
        nxt[i] = merge_word(gp_q[i], bus.wr_data, bus.wr_en, bus.wr_hi_en, bus.wr_lo_en);
    end
    cur[ZERO_IDX] = '0;
    nxt[ZERO_IDX] = '0;
    cur[PC_IDX]   = pc_q;
    nxt[PC_IDX]   = pc_nxt;
    cur[SP_IDX]   = sp_q;
    nxt[SP_IDX]   = sp_nxt;
  end

  // Entries below BA_IDX are never stored here; PC and SP have their own state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) gp_q[i] <= '0;
      pc_q <= '0;
    end else begin
      for (int i = BA_IDX; i < NREGS; i++) gp_q[i] <= nxt[i];
      pc_q <= pc_nxt;
    end
  end

  stack_ptr_ctrl #(
    .WIDTH    (WIDTH),
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp (
    .clk     (clk),
    .rst     (rst),
    .sp_inc  (bus.sp_inc),
    .sp_dec  (bus.sp_dec),
    .stk_clr (bus.stk_clr),
    .wr_hit  (sp_wr_hit),
    .wr_val  (sp_wr_val),
    .sp_q    (sp_q),
    .sp_nxt  (sp_nxt),
    .stk_ovf (bus.stk_ovf),
    .stk_unf (bus.stk_unf)
  );

`ifdef REGFILE_BYPASS_EN
  assign bus.rd_a = nxt[bus.rd_a_sel];
  assign bus.rd_b = nxt[bus.rd_b_sel];
  assign bus.pc   = pc_nxt;
  assign bus.sp   = sp_nxt;
`else
  assign bus.rd_a = cur[bus.rd_a_sel];
  assign bus.rd_b = cur[bus.rd_b_sel];
  assign bus.pc   = pc_q;
  assign bus.sp   = sp_q;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed test of register_file: reset, writes, byte lanes, PC and SP rules.
module tb_register_file;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  register_file_if #(.WIDTH(16), .NREGS(16)) bus ();

  register_file #(.WIDTH(16), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.wr_hi_en = 0; bus.wr_lo_en = 0;
    bus.pc_inc = 0; bus.pc_load = 0; bus.sp_inc = 0; bus.sp_dec = 0; bus.stk_clr = 0;
  endtask

  initial begin
    clk = 0; rst = 1; n_assert = 0; n_fail = 0;
    bus.rd_a_sel = 4'd5; bus.rd_b_sel = 4'd5; bus.wr_sel = 4'd0;
    bus.wr_data = '0; bus.pc_target = '0;
    idle();

    // reset
    #2 rst = 0;
    #1;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_sp", bus.sp, 16'h00FF);
    chk("rst_rd_a5", bus.rd_a, 16'h0000);
    chk("rst_ovf", {15'd0, bus.stk_ovf}, 16'h0000);
    chk("rst_unf", {15'd0, bus.stk_unf}, 16'h0000);
    tick(); tick();
    rst = 1;

    // three increments
    bus.pc_inc = 1;
    tick(); tick(); tick();
    idle();
    chk("pc_inc3", bus.pc, 16'h0003);

    // full write then byte lanes
    bus.wr_sel = 4'd5; bus.wr_data = 16'h1234; bus.wr_en = 1;
    tick();
    idle(); bus.wr_data = 16'h00AB; bus.wr_hi_en = 1;
    tick();
    idle();
    chk("hi_lane", bus.rd_a, 16'hAB34);
    bus.wr_data = 16'h00CD; bus.wr_lo_en = 1;
    tick();
    idle();
    chk("lo_lane", bus.rd_a, 16'hABCD);
    bus.wr_data = 16'h1277; bus.wr_en = 1; bus.wr_hi_en = 1; bus.wr_lo_en = 1;
    tick();
    idle();
    chk("all_lanes", bus.rd_a, 16'h7777);

    // register 0 discards writes
    bus.wr_sel = 4'd0; bus.wr_data = 16'hFFFF; bus.wr_en = 1;
    tick();
    idle();
    bus.rd_a_sel = 4'd0;
    #1;
    chk("r0_zero", bus.rd_a, 16'h0000);
    chk("r5_kept", bus.rd_b, 16'h7777);

    // PC priority
    bus.pc_inc = 1; bus.pc_load = 1; bus.pc_target = 16'h0400;
    tick();
    idle();
    chk("pc_load_wins", bus.pc, 16'h0400);
    bus.wr_sel = 4'd1; bus.wr_data = 16'h1111; bus.wr_en = 1; bus.pc_inc = 1;
    tick();
    idle();
    chk("pc_inc_over_wr", bus.pc, 16'h0401);
    bus.wr_data = 16'h2000; bus.wr_en = 1;
    tick();
    idle();
    bus.rd_a_sel = 4'd1;
    #1;
    chk("pc_gen_wr", bus.rd_a, 16'h2000);
    bus.pc_load = 1; bus.pc_target = 16'hFFFF;
    tick();
    idle(); bus.pc_inc = 1;
    tick();
    idle();
    chk("pc_wrap", bus.pc, 16'h0000);

    // SP push to limit, overflow
    bus.wr_sel = 4'd2; bus.wr_data = 16'h0081; bus.wr_en = 1;
    tick();
    idle();
    chk("sp_gen_wr", bus.sp, 16'h0081);
    bus.sp_dec = 1;
    tick();
    chk("sp_dec1", bus.sp, 16'h0080);
    chk("ovf_not_yet", {15'd0, bus.stk_ovf}, 16'h0000);
    tick();
    chk("sp_hold_limit", bus.sp, 16'h0080);
    chk("ovf_set", {15'd0, bus.stk_ovf}, 16'h0001);
    bus.stk_clr = 1;
    tick();
    idle();
    chk("ovf_set_wins", {15'd0, bus.stk_ovf}, 16'h0001);
    bus.stk_clr = 1;
    tick();
    idle();
    chk("ovf_cleared", {15'd0, bus.stk_ovf}, 16'h0000);

    // SP op overrides general write
    bus.wr_sel = 4'd2; bus.wr_data = 16'h1234; bus.wr_en = 1; bus.sp_inc = 1;
    tick();
    idle();
    chk("sp_op_over_wr", bus.sp, 16'h0081);

    // inc+dec cancels
    bus.sp_inc = 1; bus.sp_dec = 1;
    tick();
    idle();
    chk("sp_cancel_mid", bus.sp, 16'h0081);

    // pop at top, underflow
    bus.wr_sel = 4'd2; bus.wr_data = 16'h00FF; bus.wr_en = 1;
    tick();
    idle(); bus.sp_inc = 1;
    tick();
    idle();
    chk("sp_hold_top", bus.sp, 16'h00FF);
    chk("unf_set", {15'd0, bus.stk_unf}, 16'h0001);
    chk("ovf_still_0", {15'd0, bus.stk_ovf}, 16'h0000);
    bus.sp_inc = 1; bus.sp_dec = 1;
    tick();
    idle();
    chk("sp_cancel_top", bus.sp, 16'h00FF);
    chk("unf_sticky", {15'd0, bus.stk_unf}, 16'h0001);
    bus.stk_clr = 1;
    tick();
    idle();
    chk("unf_cleared", {15'd0, bus.stk_unf}, 16'h0000);

    // read during write
    bus.rd_b_sel = 4'd7; bus.wr_sel = 4'd7; bus.wr_data = 16'hBEEF; bus.wr_en = 1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_same_cycle", bus.rd_b, 16'hBEEF);
`else
    chk("rdw_same_cycle", bus.rd_b, 16'h0000);
`endif
    tick();
    idle();
    chk("rdw_next_cycle", bus.rd_b, 16'hBEEF);

    // asynchronous reset mid-cycle
    bus.pc_inc = 1;
    #2 rst = 0;
    #1;
    chk("arst_pc", bus.pc, 16'h0000);
    chk("arst_sp", bus.sp, 16'h00FF);
    chk("arst_r7", bus.rd_b, 16'h0000);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
